// File: rtl/ex_adder_arb_pkg.sv
// Shared definitions for the two-port arbitrated adder.
//   PORT_A / PORT_B : source identifiers used for grant, last_grant and rsp_id
//   ST_EMPTY/ST_FULL: result-register FSM encoding
//   add_ovf         : two's-complement signed overflow from the three MSBs
package ex_adder_arb_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  function automatic logic add_ovf(input logic op1_msb,
                                   input logic op2_msb,
                                   input logic sum_msb);
    return (op1_msb == op2_msb) && (sum_msb != op1_msb);
  endfunction

endpackage

// File: rtl/EX_adder.sv
// Plain WIDTH-bit adder; carry-out is dropped (result is modulo 2^WIDTH).
//   a_i, b_i : operands
//   sum_o    : a_i + b_i
module EX_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/ex_adder_arb.sv
// Two requesters (A: branch-target unit, B: load/store address unit) share one
// adder. One request is accepted per cycle into a single result register that
// is drained with a valid/ready handshake.
//   clk, rst                         : clock, async active-high reset
//   a_req_valid/a_req_ready, a_op1/2 : port A request
//   b_req_valid/b_req_ready, b_op1/2 : port B request
//   rsp_valid/rsp_ready              : result handshake
//   rsp_id, rsp_sum, rsp_ovf         : held result (source, sum, signed ovf)
//
// state    | meaning
// ST_EMPTY | result register holds nothing (rsp_valid = 0)
// ST_FULL  | result register holds an unconsumed result
module ex_adder_arb
  import ex_adder_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RR_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic [WIDTH-1:0] a_op1,
  input  logic [WIDTH-1:0] a_op2,
  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic [WIDTH-1:0] b_op1,
  input  logic [WIDTH-1:0] b_op2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_ovf
);

  logic [0:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic             grant_vld;
  logic             grant_id;
  logic             slot_free;
  logic             accept_en;
  logic             xfer;
  logic [WIDTH-1:0] op1_mux, op2_mux, sum_w;

  always_comb begin
    grant_vld = a_req_valid || b_req_valid;
    grant_id  = PORT_A;
    if (a_req_valid && b_req_valid) begin
      // With round-robin, the port that did not win last time goes first.
      grant_id = ((RR_EN != 0) && (last_grant_q == PORT_A)) ? PORT_B : PORT_A;
    end else if (b_req_valid) begin
      grant_id = PORT_B;
    end
  end

  assign slot_free = (state_q == ST_EMPTY) || rsp_ready;
  // Reset is asynchronous; gate readies so nothing is offered while it is held.
  assign accept_en = slot_free && !rst;
  assign xfer      = accept_en && grant_vld;

  assign a_req_ready = accept_en && grant_vld && (grant_id == PORT_A);
  assign b_req_ready = accept_en && grant_vld && (grant_id == PORT_B);

  assign op1_mux = (grant_id == PORT_B) ? b_op1 : a_op1;
  assign op2_mux = (grant_id == PORT_B) ? b_op2 : a_op2;

  EX_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i   (op1_mux),
    .b_i   (op2_mux),
    .sum_o (sum_w)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_ovf_d    = rsp_ovf_q;
    if (xfer) begin
      state_d      = ST_FULL;
      last_grant_d = grant_id;
      rsp_id_d     = grant_id;
      rsp_sum_d    = sum_w;
      rsp_ovf_d    = add_ovf(op1_mux[WIDTH-1], op2_mux[WIDTH-1], sum_w[WIDTH-1]);
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= PORT_B;
      rsp_id_q     <= PORT_A;
      rsp_sum_q    <= '0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_ex_adder_arb.sv
module tb_ex_adder_arb;

  localparam int W = 32;

  logic         clk, rst;
  logic         a_req_valid, b_req_valid, rsp_ready;
  logic [W-1:0] a_op1, a_op2, b_op1, b_op2;

  logic         a_req_ready, b_req_ready, rsp_valid, rsp_id, rsp_ovf;
  logic [W-1:0] rsp_sum;
  logic         a_req_ready_n, b_req_ready_n, rsp_valid_n, rsp_id_n, rsp_ovf_n;
  logic [W-1:0] rsp_sum_n;

  int total = 0;
  int bad   = 0;

  ex_adder_arb #(.WIDTH(W), .RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_op1(a_op1), .a_op2(a_op2),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_op1(b_op1), .b_op2(b_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf)
  );

  ex_adder_arb #(.WIDTH(W), .RR_EN(0)) dut_fixed (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready_n), .a_op1(a_op1), .a_op2(a_op2),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready_n), .b_op1(b_op1), .b_op2(b_op2),
    .rsp_valid(rsp_valid_n), .rsp_ready(rsp_ready), .rsp_id(rsp_id_n),
    .rsp_sum(rsp_sum_n), .rsp_ovf(rsp_ovf_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    a_req_valid = 1'b1; b_req_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rsp_valid); end
    total++; if (rsp_sum !== 32'h0) begin bad++; $display("FAIL reset_sum got=%h exp=0", rsp_sum); end
    total++; if (rsp_ovf !== 1'b0 || rsp_id !== 1'b0) begin bad++; $display("FAIL reset_ovf_id got=%0b%0b exp=00", rsp_ovf, rsp_id); end
    total++; if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b%0b exp=00", a_req_ready, b_req_ready); end
    step();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid got=%0b exp=0", rsp_valid); end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_a_only();
    a_req_valid = 1'b1; a_op1 = 32'h0000_0010; a_op2 = 32'h0000_0004; rsp_ready = 1'b1;
    #1;
    total++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) begin bad++; $display("FAIL a_only_ready got=%0b%0b exp=10", a_req_ready, b_req_ready); end
    step();
    a_req_valid = 1'b0; a_op1 = 32'hDEAD_BEEF;
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin bad++; $display("FAIL a_only_vld_id got=%0b%0b exp=10", rsp_valid, rsp_id); end
    total++; if (rsp_sum !== 32'h0000_0014 || rsp_ovf !== 1'b0) begin bad++; $display("FAIL a_only_sum got=%h/%0b exp=00000014/0", rsp_sum, rsp_ovf); end
    step();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL a_only_drain got=%0b exp=0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic exp_id;
    apply_reset();
    a_req_valid = 1'b1; a_op1 = 32'd1; a_op2 = 32'd1;
    b_req_valid = 1'b1; b_op1 = 32'd2; b_op2 = 32'd2;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      #1;
      total++; if (a_req_ready !== !exp_id || b_req_ready !== exp_id) begin bad++; $display("FAIL rr_ready[%0d] got=%0b%0b exp=%0b%0b", i, a_req_ready, b_req_ready, !exp_id, exp_id); end
      total++; if (a_req_ready_n !== 1'b1 || b_req_ready_n !== 1'b0) begin bad++; $display("FAIL fixed_ready[%0d] got=%0b%0b exp=10", i, a_req_ready_n, b_req_ready_n); end
      step();
      total++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_sum !== (exp_id ? 32'd4 : 32'd2)) begin bad++; $display("FAIL rr_rsp[%0d] got=%0b/%0b/%h exp=1/%0b/%h", i, rsp_valid, rsp_id, rsp_sum, exp_id, exp_id ? 32'd4 : 32'd2); end
      total++; if (rsp_id_n !== 1'b0 || rsp_sum_n !== 32'd2) begin bad++; $display("FAIL fixed_rsp[%0d] got=%0b/%h exp=0/00000002", i, rsp_id_n, rsp_sum_n); end
    end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    rsp_ready = 1'b1;
    a_req_valid = 1'b1; a_op1 = 32'h7FFF_FFFF; a_op2 = 32'h0000_0001;
    step();
    total++; if (rsp_sum !== 32'h8000_0000 || rsp_ovf !== 1'b1) begin bad++; $display("FAIL ovf_pos got=%h/%0b exp=80000000/1", rsp_sum, rsp_ovf); end
    a_op1 = 32'hFFFF_FFFF; a_op2 = 32'h0000_0001;
    step();
    total++; if (rsp_sum !== 32'h0 || rsp_ovf !== 1'b0) begin bad++; $display("FAIL wrap got=%h/%0b exp=00000000/0", rsp_sum, rsp_ovf); end
    a_req_valid = 1'b0;
    b_req_valid = 1'b1; b_op1 = 32'h8000_0000; b_op2 = 32'h8000_0000;
    step();
    total++; if (rsp_sum !== 32'h0 || rsp_ovf !== 1'b1 || rsp_id !== 1'b1) begin bad++; $display("FAIL ovf_neg got=%h/%0b/%0b exp=00000000/1/1", rsp_sum, rsp_ovf, rsp_id); end
    b_req_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_op1 = 32'h5; a_op2 = 32'h6;
    step();
    a_req_valid = 1'b0; a_op1 = 32'h1234;
    b_req_valid = 1'b1; b_op1 = 32'hAAAA; b_op2 = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (b_req_ready !== 1'b0 || a_req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%0b%0b exp=00", i, a_req_ready, b_req_ready); end
      step();
      total++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'hB || rsp_id !== 1'b0) begin bad++; $display("FAIL bp_hold[%0d] got=%0b/%h/%0b exp=1/0000000b/0", i, rsp_valid, rsp_sum, rsp_id); end
    end
    b_op1 = 32'h100; b_op2 = 32'h1;
    rsp_ready = 1'b1;
    #1;
    total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL bp_accept got=%0b exp=1", b_req_ready); end
    step();
    b_req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'h101 || rsp_id !== 1'b1) begin bad++; $display("FAIL bp_result got=%0b/%h/%0b exp=1/00000101/1", rsp_valid, rsp_sum, rsp_id); end
    step();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_op1 = 32'h77; a_op2 = 32'h1;
    step();
    a_req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'h78) begin bad++; $display("FAIL mid_full got=%0b/%h exp=1/00000078", rsp_valid, rsp_sum); end
    #2 rst = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_sum !== 32'h0) begin bad++; $display("FAIL mid_async got=%0b/%h exp=0/00000000", rsp_valid, rsp_sum); end
    #1 rst = 1'b0;
    step();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_discard got=%0b exp=0", rsp_valid); end
    a_req_valid = 1'b1; a_op1 = 32'h3; a_op2 = 32'h4;
    b_req_valid = 1'b1; b_op1 = 32'h10; b_op2 = 32'h20;
    rsp_ready = 1'b1;
    #1;
    total++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) begin bad++; $display("FAIL mid_grant got=%0b%0b exp=10", a_req_ready, b_req_ready); end
    step();
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    total++; if (rsp_id !== 1'b0 || rsp_sum !== 32'h7) begin bad++; $display("FAIL mid_rsp got=%0b/%h exp=0/00000007", rsp_id, rsp_sum); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = 1'b0; b_req_valid = 1'b0; rsp_ready = 1'b0;
    a_op1 = '0; a_op2 = '0; b_op1 = '0; b_op2 = '0;
    test_reset();
    test_a_only();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_adder_arb.md
EX_ADDER_ARB -- requirements
Module: ex_adder_arb

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Parameter: RR_EN, 1, round-robin arbitration when 1; fixed priority to port A when 0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 a_req_valid  input  1  port A (branch-target unit) request valid.
REQ-006 a_req_ready  output  1  port A request accepted this cycle.
REQ-007 a_op1, a_op2  input  WIDTH each  port A operands.
REQ-008 b_req_valid  input  1  port B (load/store address unit) request valid.
REQ-009 b_req_ready  output  1  port B request accepted this cycle.
REQ-010 b_op1, b_op2  input  WIDTH each  port B operands.
REQ-011 rsp_valid  output  1  result register holds an unconsumed result.
REQ-012 rsp_ready  input  1  consumer takes the result this cycle.
REQ-013 rsp_id  output  1  source of the held result: 0 = A, 1 = B.
REQ-014 rsp_sum  output  WIDTH  op1 + op2, modulo 2^WIDTH.
REQ-015 rsp_ovf  output  1  two's-complement signed overflow of the held sum.

Function
REQ-016 The block shall share one WIDTH-bit adder between ports A and B; at most one request is accepted per cycle.
REQ-017 slot_free = !rsp_valid || rsp_ready; no request is accepted when slot_free = 0.
REQ-018 Grant, combinational: only one port valid -> that port; both valid -> port != last_grant (RR_EN = 1) or port A (RR_EN = 0); neither valid -> none.
REQ-019 x_req_ready = slot_free && (grant == x); a transfer occurs when x_req_valid && x_req_ready.
REQ-020 On a transfer, the next edge shall load rsp_sum, rsp_ovf and rsp_id from the granted port and set rsp_valid = 1. Latency is exactly 1 cycle.
REQ-021 rsp_valid && rsp_ready with no new transfer -> rsp_valid clears on the next edge.
REQ-022 rsp_valid && rsp_ready with a simultaneous transfer -> the register reloads with the new result and rsp_valid stays 1. Full throughput is 1 result/cycle.
REQ-023 rsp_valid && !rsp_ready -> rsp_sum, rsp_ovf and rsp_id shall hold stable, and both ready outputs are 0.
REQ-024 Two-state FSM: EMPTY (rsp_valid = 0) and FULL (rsp_valid = 1).
  - EMPTY -> FULL on a transfer.
  - FULL -> EMPTY on consume without a transfer.
  - FULL -> FULL on hold, or on consume with a transfer.
REQ-025 last_grant shall update to the granted port only on a transfer.
REQ-026 rsp_ovf = (op1[MSB] == op2[MSB]) && (sum[MSB] != op1[MSB]). Carry-out is discarded.
REQ-027 Operands are sampled only in the transfer cycle; operand changes outside it have no effect.

Reset
REQ-028 Asserting rst shall immediately force rsp_valid = 0, rsp_sum = 0, rsp_ovf = 0, rsp_id = 0, FSM = EMPTY and last_grant = B, so A wins the first contention.
REQ-029 Reset asserted while FULL shall discard the held result; no response is issued for it.
REQ-030 While rst = 1, a_req_ready = 0 and b_req_ready = 0.

Structure
REQ-031 A shared package shall hold the port-ID constants (PORT_A = 0, PORT_B = 1) and the FSM state encoding (EMPTY, FULL).
REQ-032 The adder shall be the existing EX_adder module, instantiated once and fed by a WIDTH-bit operand mux.
REQ-033 Arbitration, FSM and the result register shall live in ex_adder_arb; no other sub-modules.

Verification
REQ-034 A only: op1 = 0x0000_0010, op2 = 0x0000_0004, rsp_ready = 1 -> next cycle rsp_valid = 1, rsp_id = 0, rsp_sum = 0x0000_0014, rsp_ovf = 0.
REQ-035 A and B valid every cycle, rsp_ready = 1 -> grants alternate A, B, A, B starting with A; with RR_EN = 0, A wins every cycle.
REQ-036 Overflow: 0x7FFF_FFFF + 0x0000_0001 -> rsp_sum = 0x8000_0000, rsp_ovf = 1. Wrap: 0xFFFF_FFFF + 0x0000_0001 -> rsp_sum = 0, rsp_ovf = 0.
REQ-037 Backpressure: result held with rsp_ready = 0 for 3 cycles while B is valid -> b_req_ready = 0 and rsp_sum stable; raising rsp_ready accepts B in the same cycle and the B result appears on the next edge.
REQ-038 Reset mid-operation: assert rst asynchronously while FULL with rsp_ready = 0 -> rsp_valid = 0 before the next edge; the first post-reset contention grants A.
